// File: rtl/da_lut_reader_if.sv
// Weight-load / LUT-lookup bundle between the stimulus source and the DA LUT reader.
// Producer drives load, weights and lookup addresses; consumer returns status and LUT data.
interface da_lut_reader_if #(
    parameter int unsigned K            = 8,
    parameter int unsigned DATA_WIDTH_B = 8
);
    localparam int unsigned OUT_W = DATA_WIDTH_B + $clog2(K);

    logic                               load;
    logic [K-1:0][DATA_WIDTH_B-1:0]     B_in;
    logic                               addr_valid;
    logic [K-2:0]                       addr_in;
    logic                               busy;
    logic                               ready;
    logic                               lut_valid;
    logic signed [OUT_W-1:0]            lut_data;
    logic                               drop_err;

    modport master (
        output load, B_in, addr_valid, addr_in,
        input  busy, ready, lut_valid, lut_data, drop_err
    );

    modport slave (
        input  load, B_in, addr_valid, addr_in,
        output busy, ready, lut_valid, lut_data, drop_err
    );
endinterface

// File: rtl/da_lut_reader.sv
// Captures K signed weights, builds the half-size offset-binary DA LUT one entry
// per cycle, then serves (K-1)-bit lookups with one cycle of latency.
module da_lut_reader #(
    parameter int unsigned K            = 8,
    parameter int unsigned DATA_WIDTH_B = 8
) (
    input  logic              clk,
    input  logic              rst,
    da_lut_reader_if.slave    bus
);
    localparam int unsigned OUT_W = DATA_WIDTH_B + $clog2(K);
    localparam int unsigned DEPTH = 2 ** (K - 1);
    localparam int unsigned CNT_W = K - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUILD = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                           state;
    logic [CNT_W-1:0]                 cnt;
    logic [K-1:0][DATA_WIDTH_B-1:0]   weights;
    logic signed [OUT_W-1:0]          lut [DEPTH];
    logic signed [OUT_W-1:0]          entry_c;
    logic                             write_c;

    // Offset-binary entry for the current build index; MSB weight always adds.
    always_comb begin
        entry_c = OUT_W'($signed(weights[K-1]));
        for (int i = 0; i < int'(K) - 1; i++) begin
            if (cnt[i])
                entry_c = entry_c + OUT_W'($signed(weights[i]));
            else
                entry_c = entry_c - OUT_W'($signed(weights[i]));
        end
    end

    // A load in BUILD restarts the build, so that cycle writes nothing.
    assign write_c = (state == S_BUILD) && !bus.load;

    always_ff @(posedge clk) begin
        if (write_c)
            lut[cnt] <= entry_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            weights       <= '0;
            bus.busy      <= 1'b0;
            bus.ready     <= 1'b0;
            bus.lut_valid <= 1'b0;
            bus.lut_data  <= '0;
            bus.drop_err  <= 1'b0;
        end else begin
            bus.lut_valid <= 1'b0;

            // Any lookup not actually served is a drop, including one that collides with load.
            if (bus.addr_valid && ((state != S_READY) || bus.load))
                bus.drop_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (bus.load) begin
                        weights  <= bus.B_in;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_BUILD;
                    end
                end

                S_BUILD: begin
                    if (bus.load) begin
                        weights <= bus.B_in;
                        cnt     <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        bus.busy  <= 1'b0;
                        bus.ready <= 1'b1;
                        state     <= S_READY;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_READY: begin
                    if (bus.load) begin
                        weights   <= bus.B_in;
                        cnt       <= '0;
                        bus.ready <= 1'b0;
                        bus.busy  <= 1'b1;
                        state     <= S_BUILD;
                    end else if (bus.addr_valid) begin
                        bus.lut_valid <= 1'b1;
                        bus.lut_data  <= lut[bus.addr_in];
                    end
                end

                default: begin
                    bus.busy  <= 1'b0;
                    bus.ready <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_da_lut_reader.sv
// Directed bench for da_lut_reader (K=8, 8-bit weights) with hand-computed LUT values.
module tb_da_lut_reader;
    localparam int unsigned K  = 8;
    localparam int unsigned W  = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   nbusy;
    logic signed [10:0] last_data;

    da_lut_reader_if #(.K(K), .DATA_WIDTH_B(W)) bus ();

    da_lut_reader #(.K(K), .DATA_WIDTH_B(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [W-1:0] v);
        for (int i = 0; i < int'(K); i++) bus.B_in[i] = v;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < int'(K); i++) bus.B_in[i] = W'(i);
    endtask

    // Single lookup: request on one edge, result sampled after the next.
    task automatic lookup(input string tag, input logic [K-2:0] a, input int exp);
        bus.addr_valid = 1'b1;
        bus.addr_in    = a;
        step();
        bus.addr_valid = 1'b0;
        check({tag, "_valid"}, 32'(bus.lut_valid), 1);
        check(tag, 32'(bus.lut_data), exp);
    endtask

    // Counts sampled cycles with busy high, bounded so a stuck build cannot hang.
    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            n++;
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst            = 1'b1;
        bus.load       = 1'b0;
        bus.addr_valid = 1'b0;
        bus.addr_in    = '0;
        set_all('0);
        step();
        step();
        check("rst_busy",      32'(bus.busy), 0);
        check("rst_ready",     32'(bus.ready), 0);
        check("rst_lut_valid", 32'(bus.lut_valid), 0);
        check("rst_lut_data",  32'(bus.lut_data), 0);
        check("rst_drop_err",  32'(bus.drop_err), 0);
        rst = 1'b0;
        step();

        // All weights = 1
        set_all(8'd1);
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        count_busy(nbusy);
        check("ones_busy_cycles", nbusy, 128);
        check("ones_ready", 32'(bus.ready), 1);
        lookup("ones_a00", 7'h00, -6);
        lookup("ones_a7f", 7'h7F, 8);
        lookup("ones_a01", 7'h01, -4);

        // Ramp weights B[i] = i
        set_ramp();
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        check("ramp_ready_cleared", 32'(bus.ready), 0);
        count_busy(nbusy);
        check("ramp_busy_cycles", nbusy, 128);
        lookup("ramp_a7f", 7'h7F, 28);
        lookup("ramp_a00", 7'h00, -14);
        lookup("ramp_a55", 7'h55, 10);

        // All weights = -128: entry = 768 - 256*popcount(addr)
        set_all(8'h80);
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        count_busy(nbusy);
        check("neg_busy_cycles", nbusy, 128);
        lookup("neg_a00", 7'h00, 768);
        lookup("neg_a7f", 7'h7F, -1024);
        check("neg_no_drop", 32'(bus.drop_err), 0);

        // Four back-to-back lookups
        bus.addr_valid = 1'b1;
        bus.addr_in    = 7'h03;
        step();
        check("b2b0_valid", 32'(bus.lut_valid), 1);
        check("b2b0_data",  32'(bus.lut_data), 256);
        bus.addr_in = 7'h0F;
        step();
        check("b2b1_valid", 32'(bus.lut_valid), 1);
        check("b2b1_data",  32'(bus.lut_data), -256);
        bus.addr_in = 7'h40;
        step();
        check("b2b2_valid", 32'(bus.lut_valid), 1);
        check("b2b2_data",  32'(bus.lut_data), 512);
        bus.addr_in = 7'h7E;
        step();
        bus.addr_valid = 1'b0;
        check("b2b3_valid", 32'(bus.lut_valid), 1);
        check("b2b3_data",  32'(bus.lut_data), -768);
        step();
        check("b2b_idle_valid", 32'(bus.lut_valid), 0);
        check("b2b_hold_data",  32'(bus.lut_data), -768);

        // Reload: ones, drop during build, restart at cnt=60 with ramp
        set_all(8'd1);
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (30) step();
        bus.addr_valid = 1'b1;
        bus.addr_in    = 7'h00;
        step();
        bus.addr_valid = 1'b0;
        check("build_drop_valid", 32'(bus.lut_valid), 0);
        check("build_drop_err",   32'(bus.drop_err), 1);
        repeat (29) step();
        set_ramp();
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        count_busy(nbusy);
        check("restart_busy_cycles", nbusy, 128);
        check("restart_ready", 32'(bus.ready), 1);
        check("drop_sticky", 32'(bus.drop_err), 1);
        lookup("reload_a02", 7'h02, -12);
        lookup("reload_a7f", 7'h7F, 28);
        lookup("reload_a55", 7'h55, 10);

        // Load and lookup together in READY: load wins
        last_data = bus.lut_data;
        set_all(8'd1);
        bus.load       = 1'b1;
        bus.addr_valid = 1'b1;
        bus.addr_in    = 7'h00;
        step();
        bus.load       = 1'b0;
        bus.addr_valid = 1'b0;
        check("collide_valid", 32'(bus.lut_valid), 0);
        check("collide_busy",  32'(bus.busy), 1);
        check("collide_ready", 32'(bus.ready), 0);
        check("collide_data_held", 32'(bus.lut_data), 32'(last_data));

        // Asynchronous reset mid-build
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("arst_busy",     32'(bus.busy), 0);
        check("arst_ready",    32'(bus.ready), 0);
        check("arst_lut_valid",32'(bus.lut_valid), 0);
        check("arst_drop_err", 32'(bus.drop_err), 0);
        #2;
        rst = 1'b0;
        step();
        bus.addr_valid = 1'b1;
        bus.addr_in    = 7'h00;
        step();
        bus.addr_valid = 1'b0;
        check("post_rst_valid", 32'(bus.lut_valid), 0);
        check("post_rst_drop",  32'(bus.drop_err), 1);
        check("post_rst_ready", 32'(bus.ready), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
